// File: rtl/io_device_bank_pkg.sv
// Shared constants for the memory-mapped I/O bank.
// Holds the active-low seven-segment glyphs (bit order g..a) and the
// bit position of the switch-change flag in I/O read data.
package io_device_bank_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int unsigned IO_CHANGED_BIT = 31;

endpackage

// File: rtl/io_device_bank_hex_to_seven_seg.sv
// Nibble to active-low seven-segment glyph decoder (full 0-F set).
// Ports: nibble (4-bit value), seg (7-bit segments g..a, active-low).
module hex_to_seven_seg
  import io_device_bank_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/io_device_bank.sv
// Memory-mapped I/O register bank: HEX/LEDR/LEDG output registers written by
// decoded store strobes, seven-segment drive, synchronised + debounced
// switches, and a sticky switch-change flag returned on switch reads.
// Ports: clk, reset (async active-high); isHex/isLedr/isLedg write strobes;
// isIoOut/isSwitches read select; dataIn store data; sw raw switch pins;
// hex active-low segments; ledr/ledg LEDs; ioDataOut read data.
module io_device_bank
  import io_device_bank_pkg::*;
#(
  parameter int unsigned DATA_BIT_WIDTH  = 32,
  parameter int unsigned SW_WIDTH        = 10,
  parameter int unsigned LEDR_WIDTH      = 10,
  parameter int unsigned LEDG_WIDTH      = 8,
  parameter int unsigned HEX_DIGITS      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DB_CNT_WIDTH    = 18
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        isHex,
  input  logic                        isLedr,
  input  logic                        isLedg,
  input  logic                        isIoOut,
  input  logic                        isSwitches,
  input  logic [DATA_BIT_WIDTH-1:0]   dataIn,
  input  logic [SW_WIDTH-1:0]         sw,
  output logic [7*HEX_DIGITS-1:0]     hex,
  output logic [LEDR_WIDTH-1:0]       ledr,
  output logic [LEDG_WIDTH-1:0]       ledg,
  output logic [DATA_BIT_WIDTH-1:0]   ioDataOut
);

  localparam int unsigned HEX_BITS = 4 * HEX_DIGITS;
  localparam logic [DB_CNT_WIDTH-1:0] DB_LAST = DB_CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [HEX_BITS-1:0]     hexReg;
  logic [SW_WIDTH-1:0]     swMeta;
  logic [SW_WIDTH-1:0]     swSync;
  logic [SW_WIDTH-1:0]     swStable;
  logic [DB_CNT_WIDTH-1:0] dbCnt;
  logic                    swChanged;
  logic                    readSw;
  logic                    unusedDataBits;

  assign readSw = isIoOut & isSwitches;

  // Only the low bits of the store data reach any register.
  assign unusedDataBits = ^dataIn;

  // Output registers: each strobe updates its own register independently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hexReg <= '0;
      ledr   <= '0;
      ledg   <= '0;
    end else begin
      if (isHex)  hexReg <= dataIn[HEX_BITS-1:0];
      if (isLedr) ledr   <= dataIn[LEDR_WIDTH-1:0];
      if (isLedg) ledg   <= dataIn[LEDG_WIDTH-1:0];
    end
  end

  // Two-flop synchroniser for the asynchronous switch pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swMeta <= '0;
      swSync <= '0;
    end else begin
      swMeta <= sw;
      swSync <= swMeta;
    end
  end

  // Shared debounce counter; a read clears the change flag unless a new
  // debounced value lands on the same edge, so no event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swStable  <= '0;
      dbCnt     <= '0;
      swChanged <= 1'b0;
    end else begin
      if (readSw) swChanged <= 1'b0;
      if (swSync == swStable) begin
        dbCnt <= '0;
      end else if (dbCnt == DB_LAST) begin
        swStable  <= swSync;
        dbCnt     <= '0;
        swChanged <= 1'b1;
      end else begin
        dbCnt <= dbCnt + DB_CNT_WIDTH'(1);
      end
    end
  end

  // Read mux for the single-cycle load path.
  always_comb begin
    ioDataOut = '0;
    if (readSw) begin
      ioDataOut[SW_WIDTH-1:0]   = swStable;
      ioDataOut[IO_CHANGED_BIT] = swChanged;
    end
  end

  for (genvar i = 0; i < int'(HEX_DIGITS); i++) begin : g_digit
    hex_to_seven_seg uDecode (
      .nibble (hexReg[4*i +: 4]),
      .seg    (hex[7*i +: 7])
    );
  end

endmodule

// File: tb/tb_io_device_bank.sv
// Scoreboard bench for io_device_bank with a short debounce window.
module tb_io_device_bank;

  localparam int DB = 4;

  typedef struct packed {
    logic [27:0] hex;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
    logic [31:0] io;
  } expT;

  logic        clk = 1'b0;
  logic        reset;
  logic        isHex, isLedr, isLedg, isIoOut, isSwitches;
  logic [31:0] dataIn;
  logic [9:0]  sw;
  logic [27:0] hex;
  logic [9:0]  ledr;
  logic [7:0]  ledg;
  logic [31:0] ioDataOut;

  io_device_bank #(
    .DEBOUNCE_CYCLES (DB),
    .DB_CNT_WIDTH    (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .isHex      (isHex),
    .isLedr     (isLedr),
    .isLedg     (isLedg),
    .isIoOut    (isIoOut),
    .isSwitches (isSwitches),
    .dataIn     (dataIn),
    .sw         (sw),
    .hex        (hex),
    .ledr       (ledr),
    .ledg       (ledg),
    .ioDataOut  (ioDataOut)
  );

  always #5 clk = ~clk;

  // Reference glyphs, active-low g..a.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Behavioural model state.
  logic [15:0] mHex;
  logic [9:0]  mLedr, mStable, pinD1, pinD2;
  logic [7:0]  mLedg;
  logic        mChanged;
  logic [9:0]  seenQ [$];   // synchronised switch values seen since last settle

  expT expQ [$];
  int  nCompared = 0;
  int  nMismatched = 0;
  bit  stimDone = 0;

  function automatic logic [27:0] hexOf(input logic [15:0] v);
    logic [27:0] r;
    for (int i = 0; i < 4; i++) r[7*i +: 7] = glyph[v[4*i +: 4]];
    return r;
  endfunction

  task automatic modelReset();
    mHex = '0; mLedr = '0; mLedg = '0; mStable = '0; mChanged = 1'b0;
    pinD1 = '0; pinD2 = '0;
    seenQ.delete();
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic modelEdge(input bit h, input bit lr, input bit lg, input bit rd,
                           input logic [31:0] d, input logic [9:0] pin);
    logic [9:0] seen;
    bit allDiffer;
    seen  = pinD2;
    pinD2 = pinD1;
    pinD1 = pin;
    seenQ.push_back(seen);
    if (seenQ.size() > DB) void'(seenQ.pop_front());
    allDiffer = (seenQ.size() == DB);
    foreach (seenQ[i]) if (seenQ[i] == mStable) allDiffer = 0;
    if (rd) mChanged = 1'b0;
    if (allDiffer) begin
      mStable  = seen;
      mChanged = 1'b1;
      seenQ.delete();
    end
    if (h)  mHex  = d[15:0];
    if (lr) mLedr = d[9:0];
    if (lg) mLedg = d[7:0];
  endtask

  // Drive one cycle of stimulus, record the expected outputs, step the model.
  task automatic cycle(input bit h, input bit lr, input bit lg, input bit io,
                       input bit sel, input logic [31:0] d, input logic [9:0] pin);
    expT e;
    bit rd;
    @(posedge clk);
    #1;
    reset = 1'b0;
    isHex = h; isLedr = lr; isLedg = lg; isIoOut = io; isSwitches = sel;
    dataIn = d; sw = pin;
    rd = io && sel;
    e.hex  = hexOf(mHex);
    e.ledr = mLedr;
    e.ledg = mLedg;
    e.io   = rd ? ((32'(mChanged) << 31) | 32'(mStable)) : 32'h0;
    expQ.push_back(e);
    modelEdge(h, lr, lg, rd, d, pin);
  endtask

  // Assert reset mid-cycle with a read selected; outputs must clear at once.
  task automatic resetCycle();
    expT e;
    @(posedge clk);
    #1;
    reset = 1'b1;
    isHex = 0; isLedr = 0; isLedg = 0; isIoOut = 1; isSwitches = 1;
    modelReset();
    e.hex = {4{7'b1000000}}; e.ledr = '0; e.ledg = '0; e.io = '0;
    expQ.push_back(e);
  endtask

  task automatic idle(input int n, input logic [9:0] pin);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, $urandom, pin);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare each recorded expectation on the following falling edge.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("hex",       32'(hex),  32'(e.hex));
        check("ledr",      32'(ledr), 32'(e.ledr));
        check("ledg",      32'(ledg), 32'(e.ledg));
        check("ioDataOut", ioDataOut, e.io);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] pin;
    reset = 1'b1;
    isHex = 0; isLedr = 0; isLedg = 0; isIoOut = 0; isSwitches = 0;
    dataIn = '0; sw = '0;
    modelReset();
    repeat (2) @(posedge clk);

    // Reset state, then hex write with upper bits ignored.
    idle(2, 10'h000);
    cycle(1, 0, 0, 0, 0, 32'hFFFF_1A2F, 10'h000);
    idle(1, 10'h000);
    // Simultaneous LEDR/LEDG writes, hex untouched.
    cycle(0, 1, 1, 0, 0, 32'h0000_03FF, 10'h000);
    idle(1, 10'h000);
    // Held switch change, then two reads (flag set, then cleared).
    idle(8, 10'h155);
    cycle(0, 0, 0, 1, 1, 32'h0, 10'h155);
    cycle(0, 0, 0, 1, 1, 32'h0, 10'h155);
    // Three-cycle glitch must not change the stable value.
    idle(3, 10'h001);
    idle(8, 10'h155);
    cycle(0, 0, 0, 1, 1, 32'h0, 10'h155);
    // Reads on every cycle across a debounce update: set must win.
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 1, 32'h0, 10'h2AA);
    cycle(0, 0, 0, 1, 0, 32'h0, 10'h2AA);
    cycle(0, 0, 0, 0, 1, 32'h0, 10'h2AA);

    // Randomised traffic with a reset dropped into the middle.
    pin = 10'h2AA;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) resetCycle();
      if ($urandom_range(5) == 0) pin = 10'($urandom);
      else if ($urandom_range(7) == 0) pin = pin ^ 10'(1 << $urandom_range(9));
      cycle($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
            $urandom_range(2) != 0, $urandom_range(2) != 0, $urandom, pin);
    end

    stimDone = 1;
    repeat (3) @(posedge clk);
    if (expQ.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
